// File: rtl/buck_pkg.sv
// -----------------------------------------------------------------------------
// buck_pkg
// Shared definitions for the buck-converter step sequencer:
//   - default widths of the configuration, step and sample datapaths
//   - power-on configuration values (period 100, duty 50, amp 10, steps 0)
//   - the sequencer state encoding
// -----------------------------------------------------------------------------
package buck_pkg;

  localparam int BUCK_CNT_W  = 7;   // period/duty/phase counters
  localparam int BUCK_STEP_W = 14;  // step counters
  localparam int BUCK_AMP_W  = 4;   // source amplitude
  localparam int BUCK_SAMP_W = 32;  // captured solver sample

  localparam int DEF_PERIOD = 100;
  localparam int DEF_DUTY   = 50;
  localparam int DEF_AMP    = 10;
  localparam int DEF_STEPS  = 0;    // 0 selects free-run

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_WAIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/buck_pwm_phase.sv
// -----------------------------------------------------------------------------
// buck_pwm_phase
// Switching-phase counter for the buck source waveform. Holds the phase of the
// step currently presented to the solver and registers the matching switch
// state and gated source amplitude.
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   clear_i       start of a run: present phase 0
//   advance_i     move to the next step's phase (wraps after period_i-1)
//   period_i      switching period in steps (caller guarantees >= 2)
//   duty_i        on-steps per period
//   amp_i         source amplitude while the switch is on
//   phase_o       phase of the step currently presented
//   sw_o          switch state for the current step
//   e_val_o       source value for the current step
// -----------------------------------------------------------------------------
module buck_pwm_phase
  import buck_pkg::*;
#(
  parameter int CNT_W = BUCK_CNT_W,
  parameter int AMP_W = BUCK_AMP_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic [AMP_W-1:0] amp_i,
  output logic [CNT_W-1:0] phase_o,
  output logic             sw_o,
  output logic [AMP_W-1:0] e_val_o
);

  logic [CNT_W-1:0] r_phase;
  logic             r_sw;
  logic [AMP_W-1:0] r_e_val;
  logic [CNT_W-1:0] w_phase_next;
  logic             w_sw_next;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_phase_next = r_phase + 1'b1;
    if (clear_i || (r_phase >= period_i - 1'b1)) begin
      w_phase_next = '0;
    end
    // duty >= period keeps the switch on for every phase; duty 0 keeps it off.
    w_sw_next = (w_phase_next < duty_i);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_phase <= '0;
      r_sw    <= 1'b0;
      r_e_val <= '0;
    end else if (clear_i || advance_i) begin
      r_phase <= w_phase_next;
      r_sw    <= w_sw_next;
      r_e_val <= w_sw_next ? amp_i : '0;
    end
  end

  assign phase_o = r_phase;
  assign sw_o    = r_sw;
  assign e_val_o = r_e_val;

endmodule

// File: rtl/buck_step_ctrl.sv
// -----------------------------------------------------------------------------
// buck_step_ctrl
// Handshaked step sequencer for the buck-converter solver. Each step presents
// the switched source waveform, strobes the solver, waits for its completion
// and captures the output-voltage sample.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cfg_valid_i/ready_o     config write handshake (ready in IDLE/DONE only)
//   cfg_period/duty/amp/steps_i  waveform and run-length configuration
//   start_i, stop_i         begin a run / end it after the current step
//   step_o                  one-cycle step strobe to the solver
//   e_val_o, sw_o           source value and switch state for the step
//   solver_done_i, v2_i     solver completion and output voltage
//   sample_o/valid_o/idx_o  captured sample, capture strobe, step index
//   busy_o, done_o          run in progress / run finished
// -----------------------------------------------------------------------------
module buck_step_ctrl
  import buck_pkg::*;
#(
  parameter int CNT_W  = BUCK_CNT_W,
  parameter int STEP_W = BUCK_STEP_W,
  parameter int AMP_W  = BUCK_AMP_W,
  parameter int SAMP_W = BUCK_SAMP_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CNT_W-1:0]  cfg_period_i,
  input  logic [CNT_W-1:0]  cfg_duty_i,
  input  logic [AMP_W-1:0]  cfg_amp_i,
  input  logic [STEP_W-1:0] cfg_steps_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic              step_o,
  output logic [AMP_W-1:0]  e_val_o,
  output logic              sw_o,
  input  logic              solver_done_i,
  input  logic [SAMP_W-1:0] v2_i,
  output logic [SAMP_W-1:0] sample_o,
  output logic              sample_valid_o,
  output logic [STEP_W-1:0] sample_idx_o,
  output logic              busy_o,
  output logic              done_o
);

  state_e            r_state, w_state_next;
  logic [CNT_W-1:0]  r_period, r_duty;
  logic [AMP_W-1:0]  r_amp;
  logic [STEP_W-1:0] r_steps, r_count, w_count_next;
  logic              r_stop_pending;
  logic [SAMP_W-1:0] r_sample;
  logic [STEP_W-1:0] r_sample_idx;
  logic              r_sample_valid;

  logic              w_cfg_load, w_start, w_complete, w_last;
  logic [CNT_W-1:0]  w_period_in, w_period_eff, w_duty_eff;
  logic [AMP_W-1:0]  w_amp_eff;

  // A period below 2 would leave no room for an off-phase; clamp it to 2.
  assign w_period_in = (cfg_period_i < CNT_W'(2)) ? CNT_W'(2) : cfg_period_i;
  assign w_cfg_load  = cfg_valid_i & cfg_ready_o;

  // A config written in the same cycle as start_i must shape step 0, so the
  // waveform generator sees the incoming values rather than the old registers.
  assign w_period_eff = w_cfg_load ? w_period_in : r_period;
  assign w_duty_eff   = w_cfg_load ? cfg_duty_i  : r_duty;
  assign w_amp_eff    = w_cfg_load ? cfg_amp_i   : r_amp;

  always_comb begin
    w_state_next = r_state;
    cfg_ready_o  = 1'b0;
    step_o       = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    w_start      = 1'b0;
    w_complete   = 1'b0;
    w_count_next = r_count + 1'b1;
    // A stop arriving together with the completion still ends the run there.
    w_last = r_stop_pending | stop_i |
             ((r_steps != '0) && (w_count_next == r_steps));
    case (r_state)
      S_IDLE, S_DONE: begin
        cfg_ready_o = 1'b1;
        done_o      = (r_state == S_DONE);
        if (start_i) begin
          w_start      = 1'b1;
          w_state_next = S_STEP;
        end
      end
      S_STEP: begin
        step_o       = 1'b1;
        busy_o       = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (solver_done_i) begin
          w_complete   = 1'b1;
          w_state_next = w_last ? S_DONE : S_STEP;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_period       <= CNT_W'(DEF_PERIOD);
      r_duty         <= CNT_W'(DEF_DUTY);
      r_amp          <= AMP_W'(DEF_AMP);
      r_steps        <= STEP_W'(DEF_STEPS);
      r_count        <= '0;
      r_stop_pending <= 1'b0;
      r_sample       <= '0;
      r_sample_idx   <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if (w_cfg_load) begin
        r_period <= w_period_in;
        r_duty   <= cfg_duty_i;
        r_amp    <= cfg_amp_i;
        r_steps  <= cfg_steps_i;
      end
      if (w_start) begin
        r_count        <= '0;
        r_stop_pending <= 1'b0;
      end else begin
        if (busy_o && stop_i) begin
          r_stop_pending <= 1'b1;
        end
        if (w_complete) begin
          r_sample       <= v2_i;
          r_sample_idx   <= r_count;
          r_sample_valid <= 1'b1;
          r_count        <= w_count_next;  // wraps naturally in free-run
        end
      end
    end
  end

  // The waveform only moves when another step follows; after the final step
  // the outputs stay on the last step's values until the next start.
  buck_pwm_phase #(
    .CNT_W (CNT_W),
    .AMP_W (AMP_W)
  ) u_pwm (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (w_start),
    .advance_i (w_complete && (w_state_next == S_STEP)),
    .period_i  (w_period_eff),
    .duty_i    (w_duty_eff),
    .amp_i     (w_amp_eff),
    .phase_o   (),
    .sw_o      (sw_o),
    .e_val_o   (e_val_o)
  );

  assign sample_o       = r_sample;
  assign sample_idx_o   = r_sample_idx;
  assign sample_valid_o = r_sample_valid;

endmodule

// File: tb/tb_buck_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_buck_step_ctrl
// Self-checking bench for buck_step_ctrl. The bench plays the solver, and its
// expected waveform comes from the step index alone: step k has phase
// k mod period, the switch is on when that phase is below duty, and the source
// is amp while on.
// -----------------------------------------------------------------------------
module tb_buck_step_ctrl;

  localparam int CNT_W  = 7;
  localparam int STEP_W = 14;
  localparam int AMP_W  = 4;
  localparam int SAMP_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              cfg_valid_i = 1'b0;
  logic              cfg_ready_o;
  logic [CNT_W-1:0]  cfg_period_i = '0;
  logic [CNT_W-1:0]  cfg_duty_i = '0;
  logic [AMP_W-1:0]  cfg_amp_i = '0;
  logic [STEP_W-1:0] cfg_steps_i = '0;
  logic              start_i = 1'b0;
  logic              stop_i = 1'b0;
  logic              step_o;
  logic [AMP_W-1:0]  e_val_o;
  logic              sw_o;
  logic              solver_done_i = 1'b0;
  logic [SAMP_W-1:0] v2_i = '0;
  logic [SAMP_W-1:0] sample_o;
  logic              sample_valid_o;
  logic [STEP_W-1:0] sample_idx_o;
  logic              busy_o;
  logic              done_o;

  buck_step_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .cfg_period_i   (cfg_period_i),
    .cfg_duty_i     (cfg_duty_i),
    .cfg_amp_i      (cfg_amp_i),
    .cfg_steps_i    (cfg_steps_i),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .step_o         (step_o),
    .e_val_o        (e_val_o),
    .sw_o           (sw_o),
    .solver_done_i  (solver_done_i),
    .v2_i           (v2_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_idx_o   (sample_idx_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the configuration the DUT should be using.
  int m_period = 100;
  int m_duty   = 50;
  int m_amp    = 10;

  int p, d, a, s, sk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_step_o"},         step_o, 0);
    check({tag, "_e_val_o"},        e_val_o, 0);
    check({tag, "_sw_o"},           sw_o, 0);
    check({tag, "_sample_o"},       sample_o, 0);
    check({tag, "_sample_valid_o"}, sample_valid_o, 0);
    check({tag, "_sample_idx_o"},   sample_idx_o, 0);
    check({tag, "_busy_o"},         busy_o, 0);
    check({tag, "_done_o"},         done_o, 0);
    check({tag, "_cfg_ready_o"},    cfg_ready_o, 1);
  endtask

  // Called at a negedge in IDLE/DONE; returns at the negedge of the first STEP.
  task automatic start_run(input bit with_cfg, input int pp, input int dd,
                           input int aa, input int ss);
    check("cfg_ready_before_start", cfg_ready_o, 1);
    if (with_cfg) begin
      cfg_valid_i  = 1'b1;
      cfg_period_i = CNT_W'(pp);
      cfg_duty_i   = CNT_W'(dd);
      cfg_amp_i    = AMP_W'(aa);
      cfg_steps_i  = STEP_W'(ss);
      m_period     = (pp < 2) ? 2 : pp;
      m_duty       = dd;
      m_amp        = aa;
    end
    start_i = 1'b1;
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    start_i     = 1'b0;
  endtask

  // Plays the solver for n steps, the last of which must end the run.
  //   stop_k/stop_c : pulse stop_i for step stop_k, in its STEP cycle (c=0)
  //                   or in WAIT cycle c (kept below that step's latency)
  //   spur          : raise solver_done_i during every STEP cycle
  //   poke_k        : attempt a config write in the first WAIT of step poke_k
  task automatic run_steps(input int n, input int lat_min, input int lat_max,
                           input int stop_k, input int stop_c,
                           input bit spur, input int poke_k);
    for (int k = 0; k < n; k++) begin
      int          lat, ph, exp_e;
      bit          exp_sw;
      logic [31:0] v2;
      ph     = k % m_period;
      exp_sw = (ph < m_duty);
      exp_e  = exp_sw ? m_amp : 0;
      check("step_o", step_o, 1);
      check("busy_o_step", busy_o, 1);
      check("done_o_step", done_o, 0);
      check("sw_o", sw_o, exp_sw);
      check("e_val_o", e_val_o, exp_e);
      lat           = $urandom_range(lat_max, lat_min);
      solver_done_i = spur;
      v2_i          = $urandom;
      stop_i        = (k == stop_k) && (stop_c == 0);
      v2            = '0;
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk_i);
        if (c == 1) check("no_sample_in_wait", sample_valid_o, 0);
        check("step_low_in_wait", step_o, 0);
        check("busy_o_wait", busy_o, 1);
        if (k == poke_k && c == 1) begin
          check("cfg_ready_in_run", cfg_ready_o, 0);
          cfg_valid_i  = 1'b1;
          cfg_period_i = CNT_W'($urandom);
          cfg_duty_i   = CNT_W'($urandom);
          cfg_amp_i    = AMP_W'($urandom);
          cfg_steps_i  = STEP_W'($urandom);
        end else begin
          cfg_valid_i = 1'b0;
        end
        stop_i        = (k == stop_k) && (c == stop_c);
        solver_done_i = (c == lat);
        if (c == lat) begin
          v2   = $urandom;
          v2_i = v2;
        end
      end
      @(negedge clk_i);
      solver_done_i = 1'b0;
      stop_i        = 1'b0;
      cfg_valid_i   = 1'b0;
      check("sample_valid_o", sample_valid_o, 1);
      check("sample_o", sample_o, v2);
      check("sample_idx_o", sample_idx_o, k % (1 << STEP_W));
      check("done_o_at_sample", done_o, (k == n - 1));
      if (k == n - 1) check("no_step_after_last", step_o, 0);
    end
    // Stay in DONE with a stray completion: nothing may move.
    solver_done_i = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      check("done_held", done_o, 1);
      check("busy_o_done", busy_o, 0);
      check("no_step_in_done", step_o, 0);
      check("no_sample_in_done", sample_valid_o, 0);
      check("cfg_ready_done", cfg_ready_o, 1);
    end
    solver_done_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    check_reset_outputs("idle");

    // Stray completion and stop in IDLE.
    solver_done_i = 1'b1;
    stop_i        = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      check("idle_spur_sample", sample_valid_o, 0);
      check("idle_spur_step", step_o, 0);
    end
    solver_done_i = 1'b0;
    stop_i        = 1'b0;

    // Defaults, free-run, one-cycle solver: 101 steps, then stop.
    start_run(1'b0, 0, 0, 0, 0);
    run_steps(101, 1, 1, 100, 0, 1'b0, -1);

    // Counted run of 6 steps.
    start_run(1'b1, 4, 1, 7, 6);
    run_steps(6, 1, 1, -1, 0, 1'b0, -1);

    // Five-cycle solver, stop during the 3rd WAIT.
    start_run(1'b1, 4, 1, 7, 0);
    run_steps(3, 5, 5, 2, 2, 1'b0, -1);

    // Edge configurations, with stray completions in STEP.
    start_run(1'b1, 1, 1, 5, 4);
    run_steps(4, 1, 2, -1, 0, 1'b1, -1);
    start_run(1'b1, 4, 9, 6, 5);
    run_steps(5, 1, 3, -1, 0, 1'b0, -1);
    start_run(1'b1, 5, 0, 15, 4);
    run_steps(4, 2, 2, -1, 0, 1'b1, -1);
    start_run(1'b1, 0, 1, 9, 3);
    run_steps(3, 1, 1, -1, 0, 1'b0, -1);

    // Config write attempted during a run is dropped; a restart reuses it.
    start_run(1'b1, 5, 2, 3, 8);
    run_steps(8, 2, 3, -1, 0, 1'b0, 3);
    start_run(1'b0, 0, 0, 0, 0);
    run_steps(8, 1, 1, -1, 0, 1'b0, -1);

    // Random counted runs.
    repeat (8) begin
      p = $urandom_range(20, 0);
      d = $urandom_range(22, 0);
      a = $urandom_range(15, 0);
      s = $urandom_range(12, 1);
      start_run(1'b1, p, d, a, s);
      run_steps(s, 1, 4, -1, 0, 1'($urandom_range(1, 0)), -1);
    end

    // Random free-runs ended by stop.
    repeat (4) begin
      p  = $urandom_range(10, 2);
      d  = $urandom_range(10, 0);
      a  = $urandom_range(15, 0);
      sk = $urandom_range(6, 0);
      start_run(1'b1, p, d, a, 0);
      run_steps(sk + 1, 2, 4, sk, $urandom_range(1, 0), 1'b0, -1);
    end

    // Free-run across the step-index wrap.
    start_run(1'b1, 3, 1, 9, 0);
    run_steps((1 << STEP_W) + 2, 1, 1, (1 << STEP_W) + 1, 0, 1'b0, -1);

    // Reset in WAIT, then a restart on the default config.
    start_run(1'b1, 6, 3, 3, 0);
    @(negedge clk_i);
    check("busy_before_rst", busy_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("rst_mid_run");
    rst_i = 1'b0;
    @(negedge clk_i);
    m_period = 100;
    m_duty   = 50;
    m_amp    = 10;
    start_run(1'b0, 0, 0, 0, 0);
    run_steps(3, 1, 1, 2, 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/buck_step_ctrl.md
# buck_step_ctrl

Sequencer for the buck-converter solver datapath. It generates the switched source waveform (source value and switch state) one simulation time step at a time. It issues a step strobe to the solver and waits for the solver's completion handshake before advancing. On each completion it captures the output-voltage sample. The block sits between the host/config side and the fixed-point solver, replacing free-running per-clock stepping with handshaked, counted steps.

## Interface
Parameters:
- CNT_W, 7, width of period/duty/phase counters
- STEP_W, 14, width of step counters
- AMP_W, 4, width of source amplitude
- SAMP_W, 32, width of captured solver sample

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- cfg_valid_i  in  1  config write request
- cfg_ready_o  out  1  config accepted when valid&ready
- cfg_period_i  in  CNT_W  switching period in steps
- cfg_duty_i  in  CNT_W  on-steps per period
- cfg_amp_i  in  AMP_W  source amplitude while on
- cfg_steps_i  in  STEP_W  steps per run; 0 = free-run
- start_i  in  1  begin run
- stop_i  in  1  request stop after current step
- step_o  out  1  one-cycle step strobe to solver
- e_val_o  out  AMP_W  source value for current step
- sw_o  out  1  switch state for current step
- solver_done_i  in  1  solver finished current step
- v2_i  in  SAMP_W  solver output voltage
- sample_o  out  SAMP_W  captured v2_i
- sample_valid_o  out  1  one-cycle capture strobe
- sample_idx_o  out  STEP_W  step index of sample_o
- busy_o  out  1  run in progress
- done_o  out  1  run finished

## Operation
- States: IDLE, STEP, WAIT, DONE.
- Config registers: period, duty, amp, steps. Reset defaults: 100, 50, 10, 0.
- Config registers load on cfg_valid_i & cfg_ready_o. cfg_ready_o=1 only in IDLE/DONE.
- Period values 0 or 1 load as 2. A duty >= period gives a switch that is always on. A duty of 0 gives a switch that is always off.
- IDLE/DONE + start_i -> STEP:
  - phase, step count and stop_pending cleared.
  - done_o cleared.
- STEP: one cycle, step_o=1 -> WAIT.
- Waveform outputs, registered on entry to STEP and held until the next STEP:
  - sw_o = (phase < duty).
  - e_val_o = sw_o ? amp : 0.
- WAIT + solver_done_i:
  - sample_o <= v2_i and sample_idx_o <= step count, with sample_valid_o pulsing for 1 cycle.
  - step count +1; phase +1, wrapping to 0 after period-1.
  - Next state is DONE if stop_pending is set, or if steps != 0 and the new count equals steps. Otherwise STEP.
- stop_i in STEP/WAIT sets stop_pending. The current step always completes; a step is never aborted.
- stop_i in IDLE/DONE is ignored.
- solver_done_i outside WAIT is ignored, including the STEP cycle.
- Free-run: the step count wraps at 2^STEP_W and the run continues.
- DONE: done_o=1 held, busy_o=0. A new start_i restarts the run from phase 0.
- busy_o=1 in STEP and WAIT.

## Timing
- Reset values: all outputs 0, except cfg_ready_o=1 (IDLE).
- Reset mid-run returns the block to IDLE next cycle. Outputs clear; config registers return to defaults.
- step_o asserts the cycle after start_i is sampled.
- sample_valid_o asserts the cycle after solver_done_i is sampled.
- The next step_o is the same cycle as sample_valid_o.
- Minimum step cadence: 2 cycles, reached when solver_done_i is high the cycle after step_o.
- cfg write and start_i in the same IDLE cycle: the new config is used for the run.
- done_o asserts the same cycle as the final sample_valid_o.

## Structure
- Shared package buck_pkg holds:
  - the state enum;
  - the default constants (period 100, duty 50, amp 10, steps 0);
  - the width localparams.
- Sub-module buck_pwm_phase holds the phase counter with wrap, the duty compare, and the amplitude gating. Its controls are clear and advance; its outputs are phase, sw and e_val.
- The FSM, config registers and sample capture stay in buck_step_ctrl.

## Test plan
- Reset, default config, start, solver_done_i one cycle after each step_o, steps=0:
  - steps 0-49: sw_o=1, e_val_o=10.
  - steps 50-99: sw_o=0, e_val_o=0.
  - step 100 wraps to sw_o=1.
- Config period=4, duty=1, amp=7, steps=6 with a sample counter on v2_i:
  - exactly 6 step_o pulses; e_val_o sequence 7,0,0,0,7,0.
  - sample_idx_o 0-5; done_o on the 6th sample.
- Solver latency 5 cycles, stop_i pulsed during the 3rd WAIT:
  - 3rd sample still captured; no 4th step_o; DONE reached.
- Edge config values:
  - period=1 behaves as 2.
  - duty=9 with period=4 gives sw_o constantly 1.
  - duty=0 gives e_val_o constantly 0.
  - cfg_valid_i during a run: cfg_ready_o=0 and the config is unchanged.
- Extra and simultaneous events:
  - spurious solver_done_i in IDLE and in the STEP cycle produces no sample.
  - cfg write plus start_i together uses the new amp.
- rst_i asserted during WAIT:
  - next cycle IDLE, all outputs 0, cfg_ready_o=1.
  - a restart uses the defaults.
